// File: rtl/invader_fleet.sv
`default_nettype none
// ============================================================================
// invader_fleet : alive bitmap, march/drop stepping, bullet hit decode, speed-up
// Rev 1.0
// ============================================================================
module invader_fleet #(
  parameter int COLS        = 10,
  parameter int ROWS        = 2,
  parameter int GRID_W      = 32,
  parameter int XW          = 5,
  parameter int YW          = 5,
  parameter int START_LINE  = 4,
  parameter int LAND_LINE   = 28,
  parameter int BASE_PERIOD = 8,
  parameter int MIN_PERIOD  = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 tick,
  input  logic                 hit_valid,
  input  logic [XW-1:0]        hit_x,
  input  logic [YW-1:0]        hit_y,
  output logic [ROWS*COLS-1:0] invArray,
  output logic [YW-1:0]        invLine,
  output logic [XW-1:0]        fleetX,
  output logic                 dir,
  output logic                 hit_ack,
  output logic [7:0]           kills,
  output logic                 cleared,
  output logic                 landed
);

  localparam int c_N  = ROWS * COLS;
  localparam int c_PW = $clog2(BASE_PERIOD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MARCH   = 2'd1,
    S_CLEARED = 2'd2,
    S_LANDED  = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_N-1:0]  r_inv;
  logic [XW-1:0]   r_fx;
  logic [YW-1:0]   r_line;
  logic            r_dir;
  logic [c_PW-1:0] r_period;
  logic [c_PW-1:0] r_cnt;
  logic            r_ack;
  logic [7:0]      r_kills;
  logic            r_cleared;
  logic            r_landed;

  logic [XW:0]     w_dx;
  logic [YW:0]     w_dy;
  logic [c_N-1:0]  w_mask;
  logic [c_N-1:0]  w_inv_nx;
  logic            w_hit;
  logic            w_step;
  logic            w_at_edge;
  logic            w_land;

  // One extra bit on the offsets makes a bullet left of / above the formation
  // decode as a large value that can never match a cell.
  always_comb begin
    w_dx   = {1'b0, hit_x} - {1'b0, r_fx};
    w_dy   = {1'b0, hit_y} - {1'b0, r_line};
    w_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (w_dy == (YW+1)'(r) && w_dx == (XW+1)'(c)) begin
          w_mask[r*COLS+c] = 1'b1;
        end
      end
    end
    w_hit     = hit_valid && (r_state == S_MARCH) && (|(w_mask & r_inv));
    w_inv_nx  = w_hit ? (r_inv & ~w_mask) : r_inv;
    w_step    = tick && (r_cnt >= r_period - c_PW'(1));
    w_at_edge = r_dir ? (int'(r_fx) + COLS >= GRID_W) : (r_fx == '0);
    w_land    = int'(r_line) + ROWS >= LAND_LINE;
  end

  always_ff @(posedge clk) begin
    if (clr || start) begin
      r_state   <= clr ? S_IDLE : S_MARCH;
      r_inv     <= '1;
      r_fx      <= '0;
      r_line    <= YW'(START_LINE);
      r_dir     <= 1'b1;
      r_period  <= c_PW'(BASE_PERIOD);
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_kills   <= '0;
      r_cleared <= 1'b0;
      r_landed  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_state == S_MARCH) begin
        if (w_hit) begin
          r_inv <= w_inv_nx;
          r_ack <= 1'b1;
          if (r_kills != 8'hFF) r_kills <= r_kills + 8'd1;
          if (r_period > c_PW'(MIN_PERIOD)) r_period <= r_period - c_PW'(1);
        end
        if (tick) begin
          if (w_step) begin
            r_cnt <= '0;
            if (w_at_edge) begin
              r_line <= r_line + YW'(1);
              r_dir  <= ~r_dir;
            end else if (r_dir) begin
              r_fx <= r_fx + XW'(1);
            end else begin
              r_fx <= r_fx - XW'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_PW'(1);
          end
        end
        if (w_inv_nx == '0) begin
          r_state   <= S_CLEARED;
          r_cleared <= 1'b1;
        end else if (w_step && w_at_edge && w_land) begin
          r_state  <= S_LANDED;
          r_landed <= 1'b1;
        end
      end
    end
  end

  assign invArray = r_inv;
  assign invLine  = r_line;
  assign fleetX   = r_fx;
  assign dir      = r_dir;
  assign hit_ack  = r_ack;
  assign kills    = r_kills;
  assign cleared  = r_cleared;
  assign landed   = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_invader_fleet.sv
`default_nettype none
// ============================================================================
// tb_invader_fleet : directed and randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_invader_fleet;

  localparam int COLS = 10, ROWS = 2, GRID_W = 32, XW = 5, YW = 5;
  localparam int START_LINE = 4, LAND_LINE = 28, BASE_PERIOD = 8, MIN_PERIOD = 2;
  localparam int N  = ROWS * COLS;
  localparam int VW = N + YW + XW + 1 + 1 + 8 + 1 + 1;

  logic          clk = 1'b0;
  logic          clr = 1'b1, start = 1'b0, tick = 1'b0, hit_valid = 1'b0;
  logic [XW-1:0] hit_x = '0;
  logic [YW-1:0] hit_y = '0;
  logic [N-1:0]  invArray;
  logic [YW-1:0] invLine;
  logic [XW-1:0] fleetX;
  logic          dir, hit_ack, cleared, landed;
  logic [7:0]    kills;

  int n_cmp = 0;
  int n_err = 0;

  invader_fleet #(
    .COLS(COLS), .ROWS(ROWS), .GRID_W(GRID_W), .XW(XW), .YW(YW),
    .START_LINE(START_LINE), .LAND_LINE(LAND_LINE),
    .BASE_PERIOD(BASE_PERIOD), .MIN_PERIOD(MIN_PERIOD)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .tick(tick),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .invArray(invArray), .invLine(invLine), .fleetX(fleetX), .dir(dir),
    .hit_ack(hit_ack), .kills(kills), .cleared(cleared), .landed(landed)
  );

  always #5 clk = ~clk;

  // Behavioural game model: 0 idle, 1 marching, 2 cleared, 3 landed
  bit m_alive[ROWS][COLS];
  int m_fx, m_line, m_dir, m_period, m_cnt, m_kills, m_ack, m_clr, m_land, m_mode;

  task automatic m_load();
    foreach (m_alive[r, c]) m_alive[r][c] = 1'b1;
    m_fx = 0; m_line = START_LINE; m_dir = 1; m_period = BASE_PERIOD;
    m_cnt = 0; m_kills = 0; m_ack = 0; m_clr = 0; m_land = 0;
  endtask

  task automatic m_cycle(input bit do_clr, input bit do_start, input bit t,
                         input bit hv, input int hx, input int hy);
    int  oldp, dc, dr;
    bit  drop, any;
    if (do_clr || do_start) begin
      m_load();
      m_mode = do_clr ? 0 : 1;
      return;
    end
    m_ack = 0;
    if (m_mode != 1) return;
    oldp = m_period;
    dc = hx - m_fx;
    dr = hy - m_line;
    if (hv && dc >= 0 && dc < COLS && dr >= 0 && dr < ROWS && m_alive[dr][dc]) begin
      m_alive[dr][dc] = 1'b0;
      m_kills  = (m_kills < 255) ? m_kills + 1 : 255;
      m_period = (m_period - 1 < MIN_PERIOD) ? MIN_PERIOD : m_period - 1;
      m_ack    = 1;
    end
    drop = 1'b0;
    if (t) begin
      if (m_cnt >= oldp - 1) begin
        m_cnt = 0;
        if (m_dir == 1) begin
          if (m_fx + COLS < GRID_W) m_fx++;
          else begin m_line++; m_dir = 0; drop = 1'b1; end
        end else begin
          if (m_fx > 0) m_fx--;
          else begin m_line++; m_dir = 1; drop = 1'b1; end
        end
      end else begin
        m_cnt++;
      end
    end
    any = 1'b0;
    foreach (m_alive[r, c]) if (m_alive[r][c]) any = 1'b1;
    if (!any) begin
      m_mode = 2; m_clr = 1;
    end else if (drop && m_line + ROWS - 1 >= LAND_LINE) begin
      m_mode = 3; m_land = 1;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] a;
    foreach (m_alive[r, c]) a[r*COLS+c] = m_alive[r][c];
    return {a, YW'(m_line), XW'(m_fx), m_dir[0], m_ack[0], 8'(m_kills), m_clr[0], m_land[0]};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {invArray, invLine, fleetX, dir, hit_ack, kills, cleared, landed};
  endfunction

  localparam logic [VW-1:0] RST_VEC = {20'hFFFFF, 5'd4, 5'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};

  task automatic cyc(input bit c, input bit s, input bit t, input bit hv,
                     input int hx, input int hy);
    logic [XW-1:0] lx;
    logic [YW-1:0] ly;
    lx = XW'(hx);
    ly = YW'(hy);
    clr = c; start = s; tick = t; hit_valid = hv; hit_x = lx; hit_y = ly;
    m_cycle(c, s, t, hv, int'(lx), int'(ly));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++; $display("FAIL reset_values: got %h expected %h", dut_vec(), RST_VEC);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, i[0], 3, 4);
      n_cmp++;
      if (dut_vec() !== RST_VEC) begin
        n_err++; $display("FAIL idle_frozen: got %h expected %h", dut_vec(), RST_VEC);
      end
    end
  endtask

  task automatic test_march();
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      if (i == 7) begin
        n_cmp++;
        if (fleetX !== 5'd0) begin
          n_err++; $display("FAIL march_before_step: got %0d expected 0", fleetX);
        end
      end
    end
    n_cmp++;
    if (fleetX !== 5'd1) begin
      n_err++; $display("FAIL march_first_step: got %0d expected 1", fleetX);
    end
    for (int i = 0; i < 21 * 8; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL march_track: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (fleetX !== 5'd22) begin
      n_err++; $display("FAIL march_22: got %0d expected 22", fleetX);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if ({invLine, dir, fleetX} !== {5'd5, 1'b0, 5'd22}) begin
      n_err++; $display("FAIL march_drop: got line=%0d dir=%0d x=%0d expected 5 0 22",
                        invLine, dir, fleetX);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (fleetX !== 5'd21) begin
      n_err++; $display("FAIL march_left: got %0d expected 21", fleetX);
    end
  endtask

  task automatic test_hit();
    int acks;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 5);
    n_cmp++;
    if ({invArray, hit_ack, kills} !== {20'hFDFFF, 1'b1, 8'd1}) begin
      n_err++; $display("FAIL hit_first: got %h/%0d/%0d expected fdfff/1/1", invArray, hit_ack, kills);
    end
    cyc(0, 0, 0, 1, 3, 5);
    n_cmp++;
    if ({invArray, hit_ack, kills} !== {20'hFDFFF, 1'b0, 8'd1}) begin
      n_err++; $display("FAIL hit_repeat: got %h/%0d/%0d expected fdfff/0/1", invArray, hit_ack, kills);
    end
    cyc(0, 0, 0, 1, 10, 4);
    n_cmp++;
    if ({invArray, hit_ack, kills} !== {20'hFDFFF, 1'b0, 8'd1}) begin
      n_err++; $display("FAIL hit_out_of_range: got %h/%0d/%0d expected fdfff/0/1", invArray, hit_ack, kills);
    end
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      if (i == 6) begin
        n_cmp++;
        if (fleetX !== 5'd0) begin
          n_err++; $display("FAIL hit_period_early: got %0d expected 0", fleetX);
        end
      end
    end
    n_cmp++;
    if (fleetX !== 5'd1) begin
      n_err++; $display("FAIL hit_period7: got %0d expected 1", fleetX);
    end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, i < 3, 5, 4);
      acks += int'(hit_ack);
    end
    n_cmp++;
    if (acks != 1 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL hit_held: got acks=%0d vec=%h expected 1 %h", acks, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 4);
    n_cmp++;
    if ({invArray[0], fleetX, hit_ack} !== {1'b0, 5'd1, 1'b1}) begin
      n_err++; $display("FAIL simultaneous: got bit0=%0d x=%0d ack=%0d expected 0 1 1",
                        invArray[0], fleetX, hit_ack);
    end
  endtask

  task automatic test_clear();
    int ticks;
    logic [VW-1:0] frozen;
    cyc(0, 1, 0, 0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!(r == 1 && c == 9)) begin
          cyc(0, 0, 0, 1, c, START_LINE + r);
          n_cmp++;
          if (hit_ack !== 1'b1 || cleared !== 1'b0) begin
            n_err++; $display("FAIL clear_kill: got ack=%0d cleared=%0d expected 1 0", hit_ack, cleared);
          end
        end
      end
    end
    ticks = 0;
    for (int i = 0; i < 20 && fleetX == 5'd0; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      ticks++;
    end
    n_cmp++;
    if (ticks != MIN_PERIOD) begin
      n_err++; $display("FAIL clear_period_floor: got %0d expected %0d", ticks, MIN_PERIOD);
    end
    cyc(0, 0, 0, 1, int'(fleetX) + 9, int'(invLine) + 1);
    n_cmp++;
    if ({invArray, kills, cleared, hit_ack} !== {20'h0, 8'd20, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL clear_last: got %h/%0d/%0d/%0d expected 0/20/1/1",
                        invArray, kills, cleared, hit_ack);
    end
    frozen = exp_vec();
    frozen[10] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1, int'(fleetX), int'(invLine));
      n_cmp++;
      if (dut_vec() !== frozen) begin
        n_err++; $display("FAIL clear_frozen: got %h expected %h", dut_vec(), frozen);
      end
    end
    cyc(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++; $display("FAIL clear_restart: got %h expected %h", dut_vec(), RST_VEC);
    end
  endtask

  task automatic test_land();
    bit done;
    cyc(0, 1, 0, 0, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL land_track: got %h expected %h", dut_vec(), exp_vec());
      end
      if (landed || m_land != 0) done = 1'b1;
    end
    n_cmp++;
    if (!done || landed !== 1'b1 || invLine !== 5'd27 || m_line != 27) begin
      n_err++; $display("FAIL land_edge: got landed=%0d line=%0d expected 1 27", landed, invLine);
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== exp_vec() || invLine !== 5'd27) begin
      n_err++; $display("FAIL land_frozen: got %h expected %h", dut_vec(), exp_vec());
    end
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    n_cmp++;
    if (dut_vec() !== RST_VEC) begin
      n_err++; $display("FAIL land_clr: got %h expected %h", dut_vec(), RST_VEC);
    end
  endtask

  task automatic test_random();
    bit c, s, t, hv;
    int hx, hy;
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      c  = ($urandom_range(0, 599) == 0);
      s  = ($urandom_range(0, 249) == 0);
      t  = $urandom_range(0, 1) == 1;
      hv = ($urandom_range(0, 2) == 0);
      hx = m_fx + int'($urandom_range(0, COLS + 1)) - 1;
      hy = m_line + int'($urandom_range(0, ROWS + 1)) - 1;
      if (m_mode == 0 && $urandom_range(0, 19) == 0) s = 1'b1;
      cyc(c, s, t, hv, hx, hy);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_load();
    m_mode = 0;
    test_reset();
    test_march();
    test_hit();
    test_simultaneous();
    test_clear();
    test_land();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
